// File: rtl/uart_prog_loader.sv
// Boot-time loader: receives 8N1 UART bytes, packs them little-endian into 32-bit words
// and writes CELL_NUMBERS words to instruction memory from address 0, holding the CPU until done.
module uart_prog_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CELL_NUMBERS = 256,
    parameter int ADDR_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx_i,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              frame_err
);

    localparam int TIMER_W = $clog2(CLKS_PER_BIT);
    localparam logic [TIMER_W-1:0] HALF_CNT  = TIMER_W'(CLKS_PER_BIT / 2);
    localparam logic [TIMER_W-1:0] LAST_CNT  = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(CELL_NUMBERS - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic {LD_LOAD, LD_DONE} ld_state_t;

    logic               rx_meta_reg, rx_sync_reg;
    rx_state_t          rx_state_reg, rx_state_next;
    logic [TIMER_W-1:0] timer_reg, timer_next;
    logic [2:0]         bit_cnt_reg, bit_cnt_next;
    logic [7:0]         shift_reg, shift_next;
    logic               stop_wait_reg, stop_wait_next;
    logic               byte_ok, frame_bad;

    ld_state_t          ld_state_reg, ld_state_next;
    logic [1:0]         byte_idx_reg;
    logic [23:0]        word_reg;
    logic [ADDR_W-1:0]  word_cnt_reg;
    logic               mem_we_reg;
    logic [ADDR_W-1:0]  mem_addr_reg;
    logic [31:0]        mem_wdata_reg;
    logic               frame_err_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_reg <= 1'b1;
            rx_sync_reg <= 1'b1;
        end else begin
            rx_meta_reg <= uart_rx_i;
            rx_sync_reg <= rx_meta_reg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_reg  <= RX_IDLE;
            timer_reg     <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            stop_wait_reg <= 1'b0;
        end else begin
            rx_state_reg  <= rx_state_next;
            timer_reg     <= timer_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            stop_wait_reg <= stop_wait_next;
        end
    end

    always_comb begin
        rx_state_next  = rx_state_reg;
        timer_next     = timer_reg + TIMER_W'(1);
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        stop_wait_next = stop_wait_reg;
        byte_ok        = 1'b0;
        frame_bad      = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                timer_next = '0;
                if (!rx_sync_reg) rx_state_next = RX_START;
            end
            RX_START: begin
                if (timer_reg == HALF_CNT) begin
                    timer_next    = '0;
                    bit_cnt_next  = '0;
                    rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (timer_reg == LAST_CNT) begin
                    timer_next   = '0;
                    shift_next   = {rx_sync_reg, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) rx_state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                // After a bad stop bit, idle here until the line returns high
                if (stop_wait_reg) begin
                    timer_next = '0;
                    if (rx_sync_reg) begin
                        stop_wait_next = 1'b0;
                        rx_state_next  = RX_IDLE;
                    end
                end else if (timer_reg == LAST_CNT) begin
                    timer_next = '0;
                    if (rx_sync_reg) begin
                        byte_ok       = 1'b1;
                        rx_state_next = RX_IDLE;
                    end else begin
                        frame_bad      = 1'b1;
                        stop_wait_next = 1'b1;
                    end
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx_reg  <= '0;
            word_reg      <= '0;
            word_cnt_reg  <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            mem_we_reg <= 1'b0;
            if (frame_bad) frame_err_reg <= 1'b1;
            if (byte_ok && ld_state_reg == LD_LOAD) begin
                byte_idx_reg <= byte_idx_reg + 2'd1;
                case (byte_idx_reg)
                    2'd0: word_reg[7:0]   <= shift_reg;
                    2'd1: word_reg[15:8]  <= shift_reg;
                    2'd2: word_reg[23:16] <= shift_reg;
                    default: begin
                        mem_wdata_reg <= {shift_reg, word_reg};
                        mem_addr_reg  <= word_cnt_reg;
                        mem_we_reg    <= 1'b1;
                        word_cnt_reg  <= word_cnt_reg + ADDR_W'(1);
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ld_state_reg <= LD_LOAD;
        else      ld_state_reg <= ld_state_next;
    end

    always_comb begin
        ld_state_next = ld_state_reg;
        if (ld_state_reg == LD_LOAD && mem_we_reg && mem_addr_reg == LAST_ADDR)
            ld_state_next = LD_DONE;
    end

    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign load_done = (ld_state_reg == LD_DONE);
    assign cpu_hold  = (ld_state_reg != LD_DONE);
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Randomized bench for uart_prog_loader: a byte-level model predicts the memory writes,
// completion and frame-error flags; a negedge monitor records every write pulse.
module tb_uart_prog_loader;

    localparam int CPB   = 4;
    localparam int CELLS = 2;
    localparam int AW    = 1;
    localparam logic [AW-1:0] LAST_A = AW'(CELLS - 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          uart_rx_i = 1'b1;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold, load_done, frame_err;

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .CELL_NUMBERS(CELLS), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .uart_rx_i(uart_rx_i),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .load_done(load_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        obs_q[$];
    logic [7:0] m_bytes[$];
    int         m_addr;
    bit         m_done;
    bit         m_ferr;
    bit         last_pulse_seen = 1'b0;

    // Write monitor plus the one-cycle completion latency check
    always @(negedge clk) begin
        if (last_pulse_seen) begin
            chk("done_latency", {31'd0, load_done}, 32'd1);
            chk("hold_release", {31'd0, cpu_hold}, 32'd0);
        end
        last_pulse_seen = 1'b0;
        if (mem_we) begin
            obs_q.push_back('{addr: mem_addr, data: mem_wdata});
            $display("write addr=%0d data=0x%08h", mem_addr, mem_wdata);
            if (mem_addr == LAST_A) begin
                chk("done_early", {31'd0, load_done}, 32'd0);
                last_pulse_seen = 1'b1;
            end
        end
    end

    task automatic model_reset();
        m_bytes.delete();
        exp_q.delete();
        obs_q.delete();
        m_addr = 0;
        m_done = 1'b0;
        m_ferr = 1'b0;
    endtask

    task automatic drive_bit(input logic v);
        uart_rx_i = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap);
        logic [31:0] w;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
        uart_rx_i = 1'b1;
        repeat (gap) @(posedge clk);
        #1;
        if (!stop_ok) begin
            m_ferr = 1'b1;
        end else if (!m_done) begin
            m_bytes.push_back(b);
            if (m_bytes.size() == 4) begin
                w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                exp_q.push_back('{addr: AW'(m_addr), data: w});
                m_bytes.delete();
                m_addr++;
                if (m_addr == CELLS) m_done = 1'b1;
            end
        end
        $display("byte 0x%02h stop_ok=%0d", b, stop_ok);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1, 6);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        uart_rx_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("rst_we",    {31'd0, mem_we},    32'd0);
            chk("rst_addr",  {31'd0, mem_addr},  32'd0);
            chk("rst_wdata", mem_wdata,          32'd0);
            chk("rst_hold",  {31'd0, cpu_hold},  32'd1);
            chk("rst_done",  {31'd0, load_done}, 32'd0);
            chk("rst_ferr",  {31'd0, frame_err}, 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic verify(input string tag);
        chk({tag, "_nwr"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk({tag, "_addr"}, {31'd0, obs_q[i].addr}, {31'd0, exp_q[i].addr});
            chk({tag, "_data"}, obs_q[i].data, exp_q[i].data);
        end
        obs_q.delete();
        exp_q.delete();
        chk({tag, "_ferr"}, {31'd0, frame_err}, {31'd0, m_ferr});
        chk({tag, "_done"}, {31'd0, load_done}, {31'd0, m_done});
        chk({tag, "_hold"}, {31'd0, cpu_hold},  {31'd0, !m_done});
    endtask

    initial begin
        logic [AW-1:0] held_addr;
        logic [31:0]   held_data;
        int            guard;

        model_reset();
        do_reset(3);

        // Nominal two-word program
        send_word(32'h0010_0513);
        send_word(32'h0015_5593);
        verify("nominal");

        // Traffic after completion must not touch memory
        held_addr = mem_addr;
        held_data = mem_wdata;
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1, 6);
        verify("postdone");
        chk("postdone_addr", {31'd0, mem_addr}, {31'd0, held_addr});
        chk("postdone_data", mem_wdata, held_data);

        // One-cycle glitch in idle is not a byte
        do_reset(2);
        uart_rx_i = 1'b0;
        @(posedge clk);
        #1;
        uart_rx_i = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        send_word(32'h0010_0513);
        verify("glitch");

        // Bad stop bit: byte dropped, flag sticky
        do_reset(2);
        send_byte(8'hAA, 1'b0, 6);
        send_word(32'h0010_0513);
        verify("framerr");
        repeat (20) @(posedge clk);
        #1;
        chk("framerr_sticky", {31'd0, frame_err}, 32'd1);

        // Reset in the middle of a word restarts at address 0
        do_reset(2);
        send_byte(8'($urandom), 1'b1, 6);
        send_byte(8'($urandom), 1'b1, 6);
        do_reset(3);
        send_word(32'h0010_0513);
        verify("midrst");

        // Random full loads with occasional framing errors
        for (int r = 0; r < 4; r++) begin
            do_reset(1);
            guard = 0;
            while (!m_done && guard < 40) begin
                send_byte(8'($urandom), ($urandom_range(0, 7) != 0), $urandom_range(6, 12));
                guard++;
            end
            chk("rand_finished", {31'd0, m_done}, 32'd1);
            verify("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
